mem_stage: RTL and testbench

- Memory-access stage of the 5-stage scalar pipeline, between EX and the writeback stage.
- Registers the EX->MEM bus and waits for the data-SRAM load response, holding it if writeback stalls.
- Performs load byte/half selection and extension, then presents the 70-bit writeback bus {pc, rf_we, rf_waddr, final_result}.
- Exports forwarding and load-use stall information to ID.

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage scalar pipeline.
//
// Sits between EX and writeback. Holds one instruction at a time, waits for
// the data-SRAM load response when that instruction is a load, buffers the
// response if writeback is stalled, then extracts/extends the loaded byte,
// half or word and presents the writeback bus. Also exports forwarding and
// load-use stall information back to ID.
//
// Ports:
//   clk                - rising-edge clock
//   reset              - asynchronous reset, active low
//   ex_to_mem_valid    - EX offers a valid instruction
//   ex_to_mem_bus[73:0]- {pc[31:0], rf_we, rf_waddr[4:0], alu_result[31:0],
//                         is_load, load_op[2:0]}
//   mem_allowin        - this stage accepts a new instruction this cycle
//   wb_allowin         - writeback accepts this cycle
//   mem_to_wb_valid    - writeback bus is valid and ready to move
//   mem_to_wb_bus[69:0]- {pc, rf_we, rf_waddr, final_result}
//   data_sram_data_ok  - one-cycle load response strobe
//   data_sram_rdata    - load data, valid with data_ok
//   mem_fwd_we/waddr/data - forwarding info for ID
//   mem_fwd_stall      - load in this stage whose data is not yet available
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_to_mem_valid,
  input  logic [73:0] ex_to_mem_bus,
  output logic        mem_allowin,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [69:0] mem_to_wb_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_fwd_we,
  output logic [4:0]  mem_fwd_waddr,
  output logic [31:0] mem_fwd_data,
  output logic        mem_fwd_stall
);

  localparam int EX2MEM_W = 74;
  localparam int MEM2WB_W = 70;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_WAIT = 2'd1,
    LD_HELD = 2'd2
  } ldState_e;

  logic                memValid_q, memValid_d;
  logic [EX2MEM_W-1:0] bus_q, bus_d;
  logic [31:0]         rdataBuf_q, rdataBuf_d;
  ldState_e            ldState_q, ldState_d;

  logic [31:0] pc;
  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] aluResult;
  logic        isLoad;
  logic [2:0]  loadOp;
  logic        exIsLoad;

  logic        memReadyGo;
  logic [31:0] ldData;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] ldValue;
  logic [31:0] finalResult;

  assign {pc, rfWe, rfWaddr, aluResult, isLoad, loadOp} = bus_q;
  assign exIsLoad = ex_to_mem_bus[3];

  // A load may leave only once its response is present: either arriving
  // right now while waiting, or already captured in the hold buffer.
  assign memReadyGo = !isLoad
                    | ((ldState_q == LD_WAIT) & data_sram_data_ok)
                    | (ldState_q == LD_HELD);

  assign mem_allowin     = !memValid_q | (memReadyGo & wb_allowin);
  assign mem_to_wb_valid = memValid_q & memReadyGo;

  // Pipeline register: only overwritten when the stage can take a new
  // instruction, so a stalled instruction stays put.
  always_comb begin
    memValid_d = memValid_q;
    bus_d      = bus_q;
    if (mem_allowin) begin
      memValid_d = ex_to_mem_valid;
      if (ex_to_mem_valid) begin
        bus_d = ex_to_mem_bus;
      end
    end
  end

  // Load-response tracking. Whenever the stage accepts (the old instruction
  // left or the stage was empty) the state restarts from what was captured.
  // If the response arrives while writeback is stalled it is parked in
  // rdataBuf so the SRAM does not have to hold it. A data_ok seen in IDLE or
  // HELD does not belong to any pending load and is dropped.
  always_comb begin
    ldState_d  = ldState_q;
    rdataBuf_d = rdataBuf_q;
    if (mem_allowin) begin
      ldState_d = (ex_to_mem_valid & exIsLoad) ? LD_WAIT : LD_IDLE;
    end else if ((ldState_q == LD_WAIT) && data_sram_data_ok) begin
      ldState_d  = LD_HELD;
      rdataBuf_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memValid_q <= 1'b0;
      bus_q      <= '0;
      rdataBuf_q <= '0;
      ldState_q  <= LD_IDLE;
    end else begin
      memValid_q <= memValid_d;
      bus_q      <= bus_d;
      rdataBuf_q <= rdataBuf_d;
      ldState_q  <= ldState_d;
    end
  end

  // Byte/half selection uses the low address bits; misalignment was already
  // rejected upstream, so a half only ever sits at offset 0 or 2.
  assign ldData = (ldState_q == LD_HELD) ? rdataBuf_q : data_sram_rdata;
  assign ldHalf = aluResult[1] ? ldData[31:16] : ldData[15:0];

  always_comb begin
    ldByte = ldData[7:0];
    case (aluResult[1:0])
      2'd0:    ldByte = ldData[7:0];
      2'd1:    ldByte = ldData[15:8];
      2'd2:    ldByte = ldData[23:16];
      default: ldByte = ldData[31:24];
    endcase
  end

  // Unused load_op encodings fall back to a plain word load.
  always_comb begin
    ldValue = ldData;
    case (loadOp)
      3'b001:  ldValue = {{24{ldByte[7]}}, ldByte};
      3'b010:  ldValue = {24'd0, ldByte};
      3'b011:  ldValue = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  ldValue = {16'd0, ldHalf};
      default: ldValue = ldData;
    endcase
  end

  assign finalResult = isLoad ? ldValue : aluResult;

  logic [MEM2WB_W-1:0] wbBus;
  assign wbBus         = {pc, rfWe & memValid_q, rfWaddr, finalResult};
  assign mem_to_wb_bus = wbBus;

  // Register 0 is hardwired, so a write to it is never worth forwarding.
  assign mem_fwd_we    = memValid_q & rfWe & (rfWaddr != 5'd0);
  assign mem_fwd_waddr = rfWaddr;
  assign mem_fwd_data  = finalResult;
  assign mem_fwd_stall = memValid_q & isLoad & !memReadyGo;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level
// reference model and a per-cycle compare process, plus literal pins on
// hand-computed results.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_to_mem_valid;
  logic [73:0] ex_to_mem_bus;
  logic        mem_allowin;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_data;
  logic        mem_fwd_stall;

  int nVectors     = 0;
  int nMiscompares = 0;
  int nProtocol    = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .mem_allowin       (mem_allowin),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_fwd_we        (mem_fwd_we),
    .mem_fwd_waddr     (mem_fwd_waddr),
    .mem_fwd_data      (mem_fwd_data),
    .mem_fwd_stall     (mem_fwd_stall)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [73:0] mkBus(input logic [31:0] pc, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] alu,
                                        input logic isLd, input logic [2:0] op);
    return {pc, we, waddr, alu, isLd, op};
  endfunction

  // Loaded value straight from the ISA definition of each load flavour.
  function automatic logic [31:0] loadValue(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[int'(a) * 8 +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic checkBit(input string name, input logic actual, input logic expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [69:0] actual,
                             input logic [69:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [73:0] b, input logic wb,
                               input logic ok, input logic [31:0] rd);
    ex_to_mem_valid   = v;
    ex_to_mem_bus     = b;
    wb_allowin        = wb;
    data_sram_data_ok = ok;
    data_sram_rdata   = rd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // ---------------- reference model ----------------
  // The model holds the single instruction occupying the stage and, for a
  // load, whether its response has already been received.
  logic        mValid, mWe, mIsLoad, mHave;
  logic [31:0] mPc, mAlu, mData;
  logic [4:0]  mWaddr;
  logic [2:0]  mOp;

  always @(posedge clk or negedge reset) begin
    logic avail;
    if (!reset) begin
      mValid = 0; mWe = 0; mIsLoad = 0; mHave = 0;
      mPc = 0; mAlu = 0; mData = 0; mWaddr = 0; mOp = 0;
    end else begin
      avail = !mIsLoad || mHave || data_sram_data_ok;
      if (!mValid || (avail && wb_allowin)) begin
        mValid = ex_to_mem_valid;
        mHave  = 0;
        if (ex_to_mem_valid)
          {mPc, mWe, mWaddr, mAlu, mIsLoad, mOp} = ex_to_mem_bus;
      end else if (mIsLoad && !mHave && data_sram_data_ok) begin
        mHave = 1;
        mData = data_sram_rdata;
      end
    end
  end

  // Compare on every falling edge, halfway between driving and capture.
  always @(negedge clk) begin
    logic        avail, expValid, expFwdWe;
    logic [31:0] expFinal;
    avail    = !mIsLoad || mHave || data_sram_data_ok;
    expValid = mValid && avail;
    expFwdWe = mValid && mWe && (mWaddr != 5'd0);
    expFinal = mIsLoad ? loadValue(mOp, mAlu[1:0], mHave ? mData : data_sram_rdata) : mAlu;
    if (reset && data_sram_data_ok && !(mValid && mIsLoad && !mHave)) begin
      nProtocol++;
      $display("[TB] protocol note: data_ok with no load waiting at %0t, ignored", $time);
    end
    checkBit("model valid", mem_to_wb_valid, expValid);
    checkBit("model allowin", mem_allowin, !mValid || (avail && wb_allowin));
    checkBit("model stall", mem_fwd_stall, mValid && mIsLoad && !avail);
    checkBit("model fwd_we", mem_fwd_we, expFwdWe);
    if (expValid)
      checkOutput("model wb bus", mem_to_wb_bus, {mPc, mWe, mWaddr, expFinal});
    if (expFwdWe && avail) begin
      checkOutput("model fwd waddr", 70'(mem_fwd_waddr), 70'(mWaddr));
      checkOutput("model fwd data", 70'(mem_fwd_data), 70'(expFinal));
    end
  end

  // Load that waits `delay` cycles for its response with writeback open.
  task automatic slowLoad(input string name, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [2:0] op, input logic [31:0] rd, input int delay,
                          input logic [31:0] expected);
    applyStimulus(1, mkBus(pc, 1, 5'd6, alu, 1, op), 1, 0, 32'h0);
    nextCycle();
    applyStimulus(0, '0, 1, 0, 32'h0);
    for (int i = 0; i < delay; i++) begin
      settle();
      checkBit({name, " stall"}, mem_fwd_stall, 1'b1);
      nextCycle();
    end
    applyStimulus(0, '0, 1, 1, rd);
    settle();
    checkBit({name, " valid"}, mem_to_wb_valid, 1'b1);
    checkOutput({name, " result"}, 70'(mem_to_wb_bus[31:0]), 70'(expected));
    nextCycle();
    applyStimulus(0, '0, 1, 0, 32'h0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] words [3];
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;

    applyStimulus(0, '0, 1, 0, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkBit("reset valid", mem_to_wb_valid, 1'b0);
    checkBit("reset allowin", mem_allowin, 1'b1);
    checkBit("reset stall", mem_fwd_stall, 1'b0);
    checkBit("reset fwd_we", mem_fwd_we, 1'b0);
    reset = 1'b1;
    nextCycle();

    // Non-load passes through in one cycle.
    applyStimulus(1, mkBus(32'h0000_0100, 1, 5'd5, 32'h1234_5678, 0, 3'd0), 1, 0, 32'h0);
    nextCycle();
    applyStimulus(0, '0, 1, 0, 32'h0);
    settle();
    checkBit("alu valid", mem_to_wb_valid, 1'b1);
    checkOutput("alu bus", mem_to_wb_bus, {32'h0000_0100, 1'b1, 5'd5, 32'h1234_5678});
    checkBit("alu fwd_we", mem_fwd_we, 1'b1);
    nextCycle();

    slowLoad("lb", 32'h104, 32'h1000_0003, 3'd1, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    slowLoad("lbu", 32'h108, 32'h1000_0003, 3'd2, 32'h80FF_0000, 2, 32'h0000_0080);
    slowLoad("lh", 32'h10C, 32'h1000_0002, 3'd3, 32'h8001_7FFF, 0, 32'hFFFF_8001);
    slowLoad("lhu", 32'h110, 32'h1000_0000, 3'd4, 32'h8001_7FFF, 0, 32'h0000_7FFF);
    slowLoad("lw op7", 32'h114, 32'h1000_0000, 3'd7, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A);

    // Response arrives while writeback is stalled for three cycles.
    applyStimulus(1, mkBus(32'h120, 1, 5'd7, 32'h2000_0000, 1, 3'd0), 1, 0, 32'h0);
    nextCycle();
    applyStimulus(0, '0, 0, 1, 32'hCAFE_BABE);
    settle();
    checkBit("held allowin 0", mem_allowin, 1'b0);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, '0, 0, 0, 32'hDEAD_0000);
      settle();
      checkBit("held allowin", mem_allowin, 1'b0);
      checkOutput("held result", 70'(mem_to_wb_bus[31:0]), 70'(32'hCAFE_BABE));
      nextCycle();
    end
    applyStimulus(0, '0, 1, 0, 32'hDEAD_0000);
    settle();
    checkBit("held release valid", mem_to_wb_valid, 1'b1);
    nextCycle();
    applyStimulus(0, '0, 1, 0, 32'h0);
    settle();
    checkBit("held once", mem_to_wb_valid, 1'b0);
    nextCycle();

    // Three back-to-back word loads, each answered in the next cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i < 3, mkBus(32'h200 + 32'(4 * i), 1, 5'(8 + i), 32'h3000_0000, 1, 3'd0),
                    1, i > 0, (i > 0) ? words[(i > 0) ? i - 1 : 0] : 32'h0);
      if (i > 0) begin
        settle();
        checkBit("b2b valid", mem_to_wb_valid, 1'b1);
        checkBit("b2b no stall", mem_fwd_stall, 1'b0);
        checkOutput("b2b result", 70'(mem_to_wb_bus[31:0]), 70'(words[i - 1]));
      end
      nextCycle();
    end
    applyStimulus(0, '0, 1, 0, 32'h0);
    nextCycle();

    // Reset in the middle of a wait; then a stray late response.
    applyStimulus(1, mkBus(32'h300, 1, 5'd0, 32'h4000_0000, 1, 3'd0), 1, 0, 32'h0);
    nextCycle();
    applyStimulus(0, '0, 1, 0, 32'h0);
    settle();
    checkBit("r0 stall", mem_fwd_stall, 1'b1);
    checkBit("r0 fwd_we", mem_fwd_we, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkBit("midreset valid", mem_to_wb_valid, 1'b0);
    checkBit("midreset stall", mem_fwd_stall, 1'b0);
    checkBit("midreset allowin", mem_allowin, 1'b1);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    applyStimulus(0, '0, 1, 1, 32'hFFFF_FFFF);
    settle();
    checkBit("late ok valid", mem_to_wb_valid, 1'b0);
    nextCycle();
    applyStimulus(0, '0, 1, 0, 32'h0);
    settle();
    checkBit("late ok dropped", mem_to_wb_valid, 1'b0);
    nextCycle();
    checkOutput("protocol count", 70'(nProtocol), 70'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
